hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 21 ++
 rtl/hazard_scoreboard_md_busy_cnt.sv | 33 +++
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: mult/div latencies, forwarding
// stage encoding and the NOTUSE sentinel of the Tuse/Tnew fields.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned STAGE_W      = 3;
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  // Forwarding source index: 0 is the register file, 1..NSTAGE are E, M, W...
  localparam logic [STAGE_W-1:0] STG_RF = 3'd0;
  localparam logic [STAGE_W-1:0] STG_E  = 3'd1;
  localparam logic [STAGE_W-1:0] STG_M  = 3'd2;
  localparam logic [STAGE_W-1:0] STG_WB = 3'd3;

  // All-ones value of a tw-bit Tuse field marks an operand that is not read.
  function automatic int unsigned notuse(input int unsigned tw);
    return (32'd1 << tw) - 32'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_cnt.sv
// Mult/div occupancy counter: loads the op latency on an accepted start and
// counts down to zero; busy while non-zero.
module md_busy_cnt
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destinations with their
// remaining Tnew, raises stall on operand/mult-div hazards and picks forward sources.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned TW       = 3,
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d_valid,
  input  logic [REG_W-1:0]   d_rs,
  input  logic [REG_W-1:0]   d_rt,
  input  logic [TW-1:0]      d_tuse_rs,
  input  logic [TW-1:0]      d_tuse_rt,
  input  logic [REG_W-1:0]   d_wa,
  input  logic [TW-1:0]      d_tnew,
  input  logic               d_md_start,
  input  logic               d_md_div,
  input  logic               d_md_use,
  output logic               stall,
  output logic [STAGE_W-1:0] fwd_rs_stage,
  output logic [STAGE_W-1:0] fwd_rt_stage,
  output logic               md_busy
);

  localparam logic [TW-1:0] NOTUSE = TW'(notuse(TW));

  logic                         accept;
  logic [NSTAGE:1][REG_W-1:0]   wa;
  logic [NSTAGE:1][TW-1:0]      tnew;
  logic [STAGE_W-1:0]           gov_rs, gov_rt;
  logic [TW-1:0]                tnew_rs, tnew_rt;
  logic                         haz_rs, haz_rt, haz_md;

  assign accept = d_valid & ~stall;

  // Per-stage destination tracker; stage 1 is E.
  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    logic [REG_W-1:0] wa_q;
    logic [TW-1:0]    tnew_q;

    if (k == 1) begin : g_head
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wa_q   <= '0;
          tnew_q <= '0;
        end else if (accept) begin
          wa_q   <= d_wa;
          tnew_q <= d_tnew;
        end else begin
          wa_q   <= '0;
          tnew_q <= '0;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wa_q   <= '0;
          tnew_q <= '0;
        end else begin
          wa_q   <= wa[k-1];
          tnew_q <= (tnew[k-1] == '0) ? '0 : tnew[k-1] - TW'(1);
        end
      end
    end

    assign wa[k]   = wa_q;
    assign tnew[k] = tnew_q;
  end

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .start (accept & d_md_start),
    .div   (d_md_div),
    .busy  (md_busy)
  );

  // Scan from the oldest stage down so the nearest matching stage wins.
  always_comb begin
    gov_rs       = STG_RF;
    gov_rt       = STG_RF;
    tnew_rs      = '0;
    tnew_rt      = '0;
    haz_rs       = 1'b0;
    haz_rt       = 1'b0;
    haz_md       = 1'b0;
    stall        = 1'b0;
    fwd_rs_stage = STG_RF;
    fwd_rt_stage = STG_RF;

    for (int k = int'(NSTAGE); k >= 1; k--) begin
      if (wa[k] == d_rs) begin
        gov_rs  = STAGE_W'(k);
        tnew_rs = tnew[k];
      end
      if (wa[k] == d_rt) begin
        gov_rt  = STAGE_W'(k);
        tnew_rt = tnew[k];
      end
    end

    if (d_rs == '0 || d_tuse_rs == NOTUSE) gov_rs = STG_RF;
    if (d_rt == '0 || d_tuse_rt == NOTUSE) gov_rt = STG_RF;

    haz_rs = (gov_rs != STG_RF) && (tnew_rs > d_tuse_rs);
    haz_rt = (gov_rt != STG_RF) && (tnew_rt > d_tuse_rt);
    haz_md = d_valid & (d_md_use | d_md_start) & md_busy;
    stall  = haz_rs | haz_rt | haz_md;

    if (gov_rs != STG_RF && tnew_rs == '0) fwd_rs_stage = gov_rs;
    if (gov_rt != STG_RF && tnew_rt == '0) fwd_rt_stage = gov_rt;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle comparison against an
// issue-history model plus hand-computed checks of the named scenarios.
module tb_hazard_scoreboard;

  localparam int NSTAGE = 3;
  localparam int TW     = 3;
  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;
  localparam int NU     = 7;
  localparam int HIST   = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [2:0] fwd_rs_stage, fwd_rt_stage;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rst = -1;
  int md_last  = -1;
  int acc_wa   [HIST];
  int acc_tnew [HIST];

  hazard_scoreboard #(
    .NSTAGE(NSTAGE), .TW(TW), .MULT_CYC(MULT_C), .DIV_CYC(DIV_C)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use), .stall(stall), .fwd_rs_stage(fwd_rs_stage),
    .fwd_rt_stage(fwd_rt_stage), .md_busy(md_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stage k in cycle t holds whatever was accepted in cycle t-k, aged k-1 cycles.
  function automatic int stage_wa(input int k);
    int t = cyc - k;
    if (t < 0 || t <= last_rst || t >= HIST) return 0;
    return acc_wa[t];
  endfunction

  function automatic int stage_tnew(input int k);
    int t = cyc - k;
    int r;
    if (t < 0 || t <= last_rst || t >= HIST) return 0;
    r = acc_tnew[t] - (k - 1);
    return (r < 0) ? 0 : r;
  endfunction

  task automatic gov(input int src, input int tuse, output int g, output int tn);
    g = 0;
    tn = 0;
    if (src != 0 && tuse != NU) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        if (stage_wa(k) == src) begin
          g = k;
          tn = stage_tnew(k);
          break;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    int grs, grt, trs, trt, ebusy, es, efr, eft;
    if (reset) begin
      last_rst = cyc;
      md_last  = -1;
    end
    ebusy = (cyc <= md_last) ? 1 : 0;
    gov(int'(d_rs), int'(d_tuse_rs), grs, trs);
    gov(int'(d_rt), int'(d_tuse_rt), grt, trt);
    es = ((grs != 0 && trs > int'(d_tuse_rs)) ||
          (grt != 0 && trt > int'(d_tuse_rt)) ||
          (d_valid && (d_md_use || d_md_start) && ebusy == 1)) ? 1 : 0;
    efr = (grs != 0 && trs == 0) ? grs : 0;
    eft = (grt != 0 && trt == 0) ? grt : 0;
    chk("model_stall",   int'(stall),        es);
    chk("model_md_busy", int'(md_busy),      ebusy);
    chk("model_fwd_rs",  int'(fwd_rs_stage), efr);
    chk("model_fwd_rt",  int'(fwd_rt_stage), eft);
    if (cyc < HIST) begin
      if (!reset && d_valid && es == 0) begin
        acc_wa[cyc]   = int'(d_wa);
        acc_tnew[cyc] = int'(d_tnew);
        if (d_md_start) md_last = cyc + (d_md_div ? DIV_C : MULT_C);
      end else begin
        acc_wa[cyc]   = 0;
        acc_tnew[cyc] = 0;
      end
    end
  end

  task automatic set_d(input int v, input int rs, input int rt, input int trs,
                       input int trt, input int wa, input int tn, input int ms,
                       input int md, input int mu);
    d_valid    = 1'(v);
    d_rs       = 5'(rs);
    d_rt       = 5'(rt);
    d_tuse_rs  = 3'(trs);
    d_tuse_rt  = 3'(trt);
    d_wa       = 5'(wa);
    d_tnew     = 3'(tn);
    d_md_start = 1'(ms);
    d_md_div   = 1'(md);
    d_md_use   = 1'(mu);
  endtask

  task automatic nop();
    set_d(0, 0, 0, NU, NU, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  task automatic chk_out(input string nm, input int es, input int efr, input int eft);
    chk({nm, "_stall"},  int'(stall),        es);
    chk({nm, "_fwd_rs"}, int'(fwd_rs_stage), efr);
    chk({nm, "_fwd_rt"}, int'(fwd_rt_stage), eft);
  endtask

  // Hold the current D instruction until it is accepted; counts stall and busy cycles.
  task automatic hold_count(output int ns, output int nb);
    ns = 0;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      settle();
      if (md_busy === 1'b1) nb++;
      if (stall !== 1'b1) break;
      ns++;
      tick();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, nb;
    reset = 1'b1;
    nop();
    tick();
    tick();
    settle();
    chk_out("reset", 0, 0, 0);
    chk("reset_md_busy", int'(md_busy), 0);
    tick();
    reset = 1'b0;

    // load-use: tnew 2 vs tuse 1 stalls once, then W forwards to a later reader
    set_d(1, 0, 0, NU, NU, 2, 2, 0, 0, 0); settle(); chk_out("lw", 0, 0, 0); tick();
    set_d(1, 2, 2, 1, 1, 3, 1, 0, 0, 0);   settle(); chk_out("add_c1", 1, 0, 0); tick();
    settle(); chk_out("add_c2", 0, 0, 0); tick();
    set_d(1, 2, 2, 0, 0, 0, 0, 0, 0, 0);   settle(); chk_out("use_w", 0, 3, 3); tick();

    // ori then beq against $0
    set_d(1, 0, 0, NU, NU, 2, 1, 0, 0, 0); settle(); chk_out("ori", 0, 0, 0); tick();
    set_d(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);   settle(); chk_out("beq_c1", 1, 0, 0); tick();
    settle(); chk_out("beq_c2", 0, 2, 0); tick();

    // two writers of $5: the E copy wins
    set_d(1, 0, 0, NU, NU, 5, 0, 0, 0, 0); tick();
    set_d(1, 0, 0, NU, NU, 5, 0, 0, 0, 0); tick();
    set_d(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);   settle(); chk_out("near", 0, 1, 1); tick();

    // tnew equal to tuse is not a hazard
    set_d(1, 0, 0, NU, NU, 6, 2, 0, 0, 0); tick();
    set_d(1, 6, 0, 2, NU, 0, 0, 0, 0, 0);  settle(); chk_out("equal", 0, 0, 0); tick();

    // NOTUSE operand is ignored while the other operand still stalls
    set_d(1, 0, 0, NU, NU, 6, 3, 0, 0, 0); tick();
    set_d(1, 6, 6, NU, 0, 0, 0, 0, 0, 0);  settle(); chk_out("notuse", 1, 0, 0);
    nop(); tick(); tick(); tick(); tick();

    // writes to $0 never create hazards
    set_d(1, 0, 0, NU, NU, 0, 2, 0, 0, 0); tick();
    set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   settle(); chk_out("zero", 0, 0, 0); tick();

    // mult then mflo
    set_d(1, 0, 0, NU, NU, 0, 0, 1, 0, 0); settle(); chk_out("mult", 0, 0, 0); tick();
    set_d(1, 0, 0, NU, NU, 8, 1, 0, 0, 1); hold_count(ns, nb);
    chk("mflo_mult_stalls", ns, 5);
    chk("mflo_mult_busy", nb, 5);

    // div held behind mult must not reload early; then mflo waits out the div
    set_d(1, 0, 0, NU, NU, 0, 0, 1, 0, 0); tick();
    set_d(1, 0, 0, NU, NU, 0, 0, 1, 1, 0); hold_count(ns, nb);
    chk("div_behind_mult_stalls", ns, 5);
    set_d(1, 0, 0, NU, NU, 8, 1, 0, 0, 1); hold_count(ns, nb);
    chk("mflo_div_stalls", ns, 10);
    chk("mflo_div_busy", nb, 10);
    nop(); settle(); chk("md_idle", int'(md_busy), 0); tick();

    // reset in the middle of a div with a pending load-use hazard
    set_d(1, 0, 0, NU, NU, 0, 0, 1, 1, 0); settle(); chk_out("div", 0, 0, 0); tick();
    set_d(1, 0, 0, NU, NU, 4, 6, 0, 0, 0); settle(); chk_out("lw6", 0, 0, 0); tick();
    set_d(1, 4, 0, 0, NU, 9, 1, 0, 0, 1);  settle(); chk_out("pre_rst", 1, 0, 0); tick();
    reset = 1'b1;
    settle();
    chk_out("mid_rst", 0, 0, 0);
    chk("mid_rst_md_busy", int'(md_busy), 0);
    tick();
    reset = 1'b0;
    settle();
    chk_out("post_rst", 0, 0, 0);
    chk("post_rst_md_busy", int'(md_busy), 0);
    tick();
    nop(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
